iq_sampler: RTL and testbench

Parametrised successor to the fixed-rate I/Q sampler: a run-time programmable phase accumulator sets the sample rate. On each rate strobe the block pops one frame of `LANES` words (lane 0 = I, lane 1 = Q, further lanes for multi-channel use) from a show-ahead FIFO. It presents the frame to the multipliers with a valid pulse, and reports underruns and strobe overruns. It sits between the TX sample FIFO and the modulator multipliers.

---
 rtl/iq_sampler_pkg.sv | 14 +
 rtl/rate_nco.sv | 37 +++
 rtl/iq_sampler.sv | 135 +++++++++++++
 tb/tb_iq_sampler.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iq_sampler_pkg.sv
// Shared types for the I/Q sampler: frame FSM states and the lane bit-offset helper.
package sampler_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FETCH  = 2'd1,
        S_COMMIT = 2'd2
    } state_e;

    function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned width);
        return lane * width;
    endfunction

endpackage

// File: rtl/rate_nco.sv
// Phase accumulator that emits a registered one-cycle rate strobe on every carry out.
module rate_nco #(
    parameter int ACC_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [ACC_W-1:0] rate_step,
    output logic             strobe
);

    logic [ACC_W-1:0] acc_q, acc_d;
    logic             strobe_q, strobe_d;
    logic             carry;

    always_comb begin
        {carry, acc_d} = {1'b0, acc_q} + {1'b0, rate_step};
        strobe_d = carry & en;
        // Disabled: the phase restarts from zero so the first strobe after enable is deterministic.
        if (!en) begin
            acc_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q    <= '0;
            strobe_q <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            strobe_q <= strobe_d;
        end
    end

    assign strobe = strobe_q;

endmodule

// File: rtl/iq_sampler.sv
// Rate-strobed frame sampler: pops LANES words per strobe from a show-ahead FIFO.
// Build option: define IQ_SAMPLER_HOLD_EN to hold unfetched lanes at their last committed value.
module iq_sampler
    import sampler_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LANES = 2,
    parameter int ACC_W = 32,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [ACC_W-1:0]       rate_step,
    input  logic                   fifo_empty,
    input  logic [WIDTH-1:0]       fifo_data_out,
    output logic                   fifo_rd,
    output logic [LANES*WIDTH-1:0] sample,
    output logic                   sample_valid,
    output logic                   underrun,
    output logic                   strobe_overrun,
    output logic [CNT_W-1:0]       underrun_count
);

    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

    logic strobe;

    rate_nco #(.ACC_W(ACC_W)) u_nco (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .rate_step (rate_step),
        .strobe    (strobe)
    );

    state_e                 state_q, state_d;
    logic [LANE_W-1:0]      lane_q, lane_d;
    logic                   short_q, short_d;
    logic [LANES*WIDTH-1:0] shadow_q, shadow_d;
    logic [LANES*WIDTH-1:0] sample_q, sample_d;
    logic                   valid_q, valid_d;
    logic                   underrun_q, underrun_d;
    logic                   overrun_q, overrun_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [WIDTH-1:0]       fill;

    always_comb begin
        state_d    = state_q;
        lane_d     = lane_q;
        short_d    = short_q;
        shadow_d   = shadow_q;
        sample_d   = sample_q;
        valid_d    = 1'b0;
        underrun_d = 1'b0;
        count_d    = count_q;
        fifo_rd    = 1'b0;
        fill       = '0;
        overrun_d  = strobe && (state_q != S_IDLE);

        unique case (state_q)
            S_IDLE: begin
                if (strobe) begin
                    lane_d  = '0;
                    short_d = 1'b0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                fifo_rd = !fifo_empty && !short_q;
`ifdef IQ_SAMPLER_HOLD_EN
                fill = sample_q[lane_lsb(int'(lane_q), WIDTH) +: WIDTH];
`else
                fill = '0;
`endif
                if (fifo_rd) begin
                    shadow_d[lane_lsb(int'(lane_q), WIDTH) +: WIDTH] = fifo_data_out;
                end else begin
                    shadow_d[lane_lsb(int'(lane_q), WIDTH) +: WIDTH] = fill;
                    short_d = 1'b1;
                end
                // The frame is committed on the edge into S_COMMIT so the outputs are visible during it.
                if (lane_q == LAST_LANE) begin
                    state_d    = S_COMMIT;
                    sample_d   = shadow_d;
                    valid_d    = 1'b1;
                    underrun_d = short_d;
                    if (short_d && (count_q != '1)) begin
                        count_d = count_q + 1'b1;
                    end
                end else begin
                    lane_d = lane_q + 1'b1;
                end
            end
            S_COMMIT: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            lane_q     <= '0;
            short_q    <= 1'b0;
            shadow_q   <= '0;
            sample_q   <= '0;
            valid_q    <= 1'b0;
            underrun_q <= 1'b0;
            overrun_q  <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            lane_q     <= lane_d;
            short_q    <= short_d;
            shadow_q   <= shadow_d;
            sample_q   <= sample_d;
            valid_q    <= valid_d;
            underrun_q <= underrun_d;
            overrun_q  <= overrun_d;
            count_q    <= count_d;
        end
    end

    assign sample         = sample_q;
    assign sample_valid   = valid_q;
    assign underrun       = underrun_q;
    assign strobe_overrun = overrun_q;
    assign underrun_count = count_q;

endmodule

// File: tb/tb_iq_sampler.sv
// Self-checking bench for iq_sampler: queue-backed FIFO, behavioural frame model, directed and random phases.
module tb_iq_sampler;

    localparam int W  = 8;
    localparam int L  = 2;
    localparam int AW = 8;
    localparam int CW = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic           en;
    logic [AW-1:0]  rate_step;
    logic           fifo_empty;
    logic [W-1:0]   fifo_data_out;
    logic           fifo_rd;
    logic [L*W-1:0] sample;
    logic           sample_valid;
    logic           underrun;
    logic           strobe_overrun;
    logic [CW-1:0]  underrun_count;

    always #5 clk = ~clk;

    iq_sampler #(.WIDTH(W), .LANES(L), .ACC_W(AW), .CNT_W(CW)) dut (
        .clk            (clk),
        .rst            (rst),
        .en             (en),
        .rate_step      (rate_step),
        .fifo_empty     (fifo_empty),
        .fifo_data_out  (fifo_data_out),
        .fifo_rd        (fifo_rd),
        .sample         (sample),
        .sample_valid   (sample_valid),
        .underrun       (underrun),
        .strobe_overrun (strobe_overrun),
        .underrun_count (underrun_count)
    );

    int tests = 0;
    int fails = 0;

    logic [W-1:0]   fq[$];
    logic [L*W-1:0] vs[$];
    bit             vu[$];
    int             vc[$];
    int             pops = 0;
    int             ovrs = 0;
    int             cyc_n = 0;
    bit             mon_on = 1'b0;
    bit             pop_pend = 1'b0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic refresh();
        fifo_empty    = (fq.size() == 0);
        fifo_data_out = (fq.size() == 0) ? '0 : fq[0];
    endtask

    // Behavioural model: frame phase 0 = idle, 1..L = fetching lane phase-1, L+1 = commit.
    int             m_acc = 0;
    bit             m_strobe = 1'b0;
    int             m_phase = 0;
    bit             m_short = 1'b0;
    bit             m_rd;
    logic [W-1:0]   m_lane[L];
    logic [L*W-1:0] e_sample = '0;
    bit             e_valid = 1'b0;
    bit             e_under = 1'b0;
    bit             e_ovr = 1'b0;
    int             e_cnt = 0;
    logic [W-1:0]   m_fill;

    initial begin
        forever begin
            @(negedge clk);
            cyc_n++;
            if (pop_pend) begin
                if (fq.size() > 0) void'(fq.pop_front());
                pops++;
                pop_pend = 1'b0;
                refresh();
            end
            #1;
            if (mon_on) begin
                check("sample_valid", sample_valid, e_valid);
                check("sample", sample, e_sample);
                check("underrun", underrun, e_under);
                check("strobe_overrun", strobe_overrun, e_ovr);
                check("underrun_count", underrun_count, e_cnt);
                if (sample_valid) begin
                    vs.push_back(sample);
                    vu.push_back(underrun);
                    vc.push_back(cyc_n);
                end
                if (strobe_overrun) ovrs++;
            end
            #2;
            m_rd = (m_phase >= 1) && (m_phase <= L) && !fifo_empty && !m_short;
            if (mon_on) check("fifo_rd", fifo_rd, m_rd);
            pop_pend = fifo_rd;
            if (rst) begin
                m_acc = 0; m_strobe = 1'b0; m_phase = 0; m_short = 1'b0;
                e_sample = '0; e_valid = 1'b0; e_under = 1'b0; e_ovr = 1'b0; e_cnt = 0;
            end else begin
                e_valid = 1'b0;
                e_under = 1'b0;
                e_ovr   = m_strobe && (m_phase != 0);
                if (m_phase == 0) begin
                    if (m_strobe) begin
                        m_phase = 1;
                        m_short = 1'b0;
                    end
                end else if (m_phase <= L) begin
`ifdef IQ_SAMPLER_HOLD_EN
                    m_fill = e_sample[(m_phase-1)*W +: W];
`else
                    m_fill = '0;
`endif
                    if (m_rd) begin
                        m_lane[m_phase-1] = fifo_data_out;
                    end else begin
                        m_lane[m_phase-1] = m_fill;
                        m_short = 1'b1;
                    end
                    if (m_phase == L) begin
                        for (int k = 0; k < L; k++) e_sample[k*W +: W] = m_lane[k];
                        e_valid = 1'b1;
                        e_under = m_short;
                        if (m_short && e_cnt < (1 << CW) - 1) e_cnt++;
                    end
                    m_phase++;
                end else begin
                    m_phase = 0;
                end
                if (!en) begin
                    m_acc = 0;
                    m_strobe = 1'b0;
                end else begin
                    m_strobe = (m_acc + int'(rate_step)) >= (1 << AW);
                    m_acc    = (m_acc + int'(rate_step)) % (1 << AW);
                end
            end
        end
    end

    task automatic cyc();
        @(negedge clk);
        #2;
    endtask

    task automatic clear_logs();
        vs.delete(); vu.delete(); vc.delete();
        pops = 0;
        ovrs = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en  = 1'b0;
        fq.delete();
        refresh();
        cyc();
        cyc();
        rst = 1'b0;
        clear_logs();
    endtask

    task automatic wait_valids(input int n, input int budget, input string nm);
        int k = 0;
        while (vs.size() < n && k < budget) begin
            cyc();
            k++;
        end
        check(nm, vs.size() >= n, 1'b1);
    endtask

    task automatic push(input logic [W-1:0] v);
        fq.push_back(v);
        refresh();
    endtask

    logic [W-1:0] d[12];

    initial begin
        rst = 1'b1;
        en = 1'b0;
        rate_step = '0;
        refresh();
        repeat (3) cyc();
        mon_on = 1'b1;
        cyc();
        check("rst_sample", sample, 0);
        check("rst_valid", sample_valid, 0);
        check("rst_count", underrun_count, 0);
        check("rst_fifo_rd", fifo_rd, 0);
        rst = 1'b0;
        clear_logs();

        // Rate and pop order
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        rate_step = 8'd64;
        en = 1'b1;
        wait_valids(2, 40, "order_timeout");
        en = 1'b0;
        repeat (4) cyc();
        check("order_f0", vs.size() > 0 ? vs[0] : 16'hdead, 16'h2211);
        check("order_f1", vs.size() > 1 ? vs[1] : 16'hdead, 16'h4433);
        check("order_pops", pops, 4);
        check("order_frames", vs.size(), 2);
        check("order_period", vc.size() > 1 ? vc[1] - vc[0] : 0, 4);
        check("order_no_underrun", vu.size() > 1 ? (vu[0] | vu[1]) : 1'b1, 1'b0);

        // Empty FIFO
        do_reset();
        rate_step = 8'd64;
        en = 1'b1;
        wait_valids(1, 20, "empty_timeout");
        en = 1'b0;
        repeat (2) cyc();
        check("empty_pops", pops, 0);
        check("empty_sample", vs.size() > 0 ? vs[0] : 16'hdead, 16'h0000);
        check("empty_underrun", vu.size() > 0 ? vu[0] : 1'b0, 1'b1);
        check("empty_count", underrun_count, 1);

        // Half frame (previous committed frame is all zero, so both builds expect lane1 = 0)
        clear_logs();
        push(8'h5A);
        en = 1'b1;
        wait_valids(1, 20, "half_timeout");
        en = 1'b0;
        repeat (2) cyc();
        check("half_sample", vs.size() > 0 ? vs[0] : 16'hdead, 16'h005A);
        check("half_underrun", vu.size() > 0 ? vu[0] : 1'b0, 1'b1);
        check("half_pops", pops, 1);
        check("half_count", underrun_count, 2);

        // Saturation
        do_reset();
        rate_step = 8'd64;
        en = 1'b1;
        wait_valids(5, 80, "sat_timeout");
        en = 1'b0;
        repeat (2) cyc();
        check("sat_count", underrun_count, 3);
        check("sat_frames_short", vu.size() > 4 ? vu[4] : 1'b0, 1'b1);

        // Overrun
        do_reset();
        for (int i = 0; i < 12; i++) begin
            d[i] = W'($urandom);
            push(d[i]);
        end
        rate_step = 8'd255;
        en = 1'b1;
        wait_valids(4, 60, "ovr_timeout");
        en = 1'b0;
        repeat (4) cyc();
        check("ovr_seen", ovrs > 0, 1'b1);
        check("ovr_pops", pops, 2 * vs.size());
        check("ovr_f0", vs.size() > 0 ? vs[0] : 16'hdead, {d[1], d[0]});
        check("ovr_f3", vs.size() > 3 ? vs[3] : 16'hdead, {d[7], d[6]});

        // Reset mid-frame
        do_reset();
        rate_step = 8'd64;
        en = 1'b1;
        wait_valids(1, 20, "mid_pre_timeout");
        en = 1'b0;
        cyc();
        check("mid_pre_count", underrun_count, 1);
        clear_logs();
        push(8'hA1); push(8'hB2);
        en = 1'b1;
        begin
            int k = 0;
            while (!fifo_rd && k < 20) begin
                cyc();
                k++;
            end
            check("mid_fetch_timeout", fifo_rd, 1'b1);
        end
        rst = 1'b1;
        en = 1'b0;
        cyc();
        rst = 1'b0;
        check("mid_valid", sample_valid, 0);
        check("mid_sample", sample, 0);
        check("mid_count", underrun_count, 0);
        check("mid_underrun", underrun, 0);
        check("mid_fifo_rd", fifo_rd, 0);
        repeat (6) cyc();
        check("mid_no_frame", vs.size(), 0);

        // Randomized traffic against the model
        do_reset();
        rate_step = 8'd64;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                case ($urandom_range(0, 4))
                    0: rate_step = 8'd0;
                    1: rate_step = 8'd64;
                    2: rate_step = 8'd255;
                    3: rate_step = AW'($urandom_range(1, 40));
                    default: rate_step = AW'($urandom_range(100, 200));
                endcase
            end
            if ($urandom_range(0, 24) == 0) en = !en;
            if ($urandom_range(0, 1) == 1 && fq.size() < 12) push(W'($urandom));
            rst = ($urandom_range(0, 399) == 0);
            cyc();
        end
        rst = 1'b0;
        en = 1'b0;
        repeat (8) cyc();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
